// File: rtl/noc_clk_gate_pkg.sv
// Shared types for the NoC clock-gating controller.
package noc_clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_ON    = 2'd0,
        ST_COUNT = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } ch_state_e;

    localparam int WAKE_CNT_W = $clog2(16);

endpackage

// File: rtl/axe_tcl_clk_gating.sv
// Latch-based integrated clock gate; the test enable bypasses the functional enable.
module axe_tcl_clk_gating (
    input  logic i_clk,
    input  logic i_en,
    input  logic i_test_en,
    output logic o_clk
);

    logic en_l;

    // Transparent while the clock is low so the enable can never cut a high phase short
    always_latch begin
        if (!i_clk) begin
            en_l <= i_en | i_test_en;
        end
    end

    assign o_clk = i_clk & en_l;

endmodule

// File: rtl/noc_clk_gate_ch.sv
// One gated-clock channel: idle-hysteresis FSM, wake sequencer and its ICG cell.
module noc_clk_gate_ch
    import noc_clk_gate_pkg::*;
#(
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_test_en,
    input  logic [IDLE_CNT_W-1:0] i_idle_threshold,
    input  logic                  i_idle,
    input  logic                  i_force_on,
    input  logic                  i_wake_req,
    output logic                  o_wake_ack,
    output logic                  o_clk,
    output logic                  o_gated
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYCLES - 1);
    localparam logic [IDLE_CNT_W-1:0] CNT_MAX   = {IDLE_CNT_W{1'b1}};
    localparam logic [IDLE_CNT_W-1:0] CNT_ONE   = IDLE_CNT_W'(1'b1);

    ch_state_e               state_q, state_d;
    logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [WAKE_CNT_W-1:0]   wake_cnt_q, wake_cnt_d;
    logic                    en_q, en_d;
    logic                    gated_q, gated_d;
    logic                    ack_q, ack_d;
    logic                    thr_zero_s;
    logic                    idle_ok_s;

    assign thr_zero_s = (i_idle_threshold == {IDLE_CNT_W{1'b0}});
    // A pending wake request blocks every step toward gating
    assign idle_ok_s  = i_idle & ~i_force_on & ~i_wake_req & ~thr_zero_s;

    // Next-state, counter and output decisions for the channel FSM
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        ack_d      = 1'b0;
        case (state_q)
            ST_ON: begin
                if (idle_ok_s) begin
                    state_d    = ST_COUNT;
                    idle_cnt_d = CNT_ONE;
                end else begin
                    idle_cnt_d = {IDLE_CNT_W{1'b0}};
                    ack_d      = i_wake_req & ~ack_q;
                end
            end
            ST_COUNT: begin
                if (!idle_ok_s) begin
                    state_d    = ST_ON;
                    idle_cnt_d = {IDLE_CNT_W{1'b0}};
                end else if (idle_cnt_q >= i_idle_threshold) begin
                    state_d = ST_OFF;
                end else if (idle_cnt_q != CNT_MAX) begin
                    idle_cnt_d = idle_cnt_q + CNT_ONE;
                end else begin
                    idle_cnt_d = CNT_MAX;
                end
            end
            ST_OFF: begin
                if (i_wake_req | i_force_on | ~i_idle | thr_zero_s) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = {WAKE_CNT_W{1'b0}};
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q >= WAKE_LAST) begin
                    state_d    = ST_ON;
                    wake_cnt_d = {WAKE_CNT_W{1'b0}};
                    ack_d      = i_wake_req;
                end else begin
                    wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1'b1);
                end
            end
            default: begin
                state_d    = ST_ON;
                idle_cnt_d = {IDLE_CNT_W{1'b0}};
                wake_cnt_d = {WAKE_CNT_W{1'b0}};
            end
        endcase
        en_d    = (state_d != ST_OFF);
        gated_d = (state_d == ST_OFF);
    end

    // Channel state, counters and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_ON;
            idle_cnt_q <= {IDLE_CNT_W{1'b0}};
            wake_cnt_q <= {WAKE_CNT_W{1'b0}};
            en_q       <= 1'b1;
            gated_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            en_q       <= en_d;
            gated_q    <= gated_d;
            ack_q      <= ack_d;
        end
    end

    assign o_wake_ack = ack_q;
    assign o_gated    = gated_q;

    axe_tcl_clk_gating u_icg (
        .i_clk     (i_clk),
        .i_en      (en_q),
        .i_test_en (i_test_en),
        .o_clk     (o_clk)
    );

endmodule

// File: rtl/noc_clk_gate_ctrl.sv
// Multi-channel hysteresis clock-gating controller for NoC sub-domains.
module noc_clk_gate_ctrl
    import noc_clk_gate_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_test_en,
    input  logic [IDLE_CNT_W-1:0] i_idle_threshold,
    input  logic [NUM_CH-1:0]     i_idle,
    input  logic [NUM_CH-1:0]     i_force_on,
    input  logic [NUM_CH-1:0]     i_wake_req,
    output logic [NUM_CH-1:0]     o_wake_ack,
    output logic [NUM_CH-1:0]     o_clk,
    output logic [NUM_CH-1:0]     o_gated
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        noc_clk_gate_ch #(
            .IDLE_CNT_W  (IDLE_CNT_W),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_ch (
            .i_clk            (i_clk),
            .i_rst            (i_rst),
            .i_test_en        (i_test_en),
            .i_idle_threshold (i_idle_threshold),
            .i_idle           (i_idle[g]),
            .i_force_on       (i_force_on[g]),
            .i_wake_req       (i_wake_req[g]),
            .o_wake_ack       (o_wake_ack[g]),
            .o_clk            (o_clk[g]),
            .o_gated          (o_gated[g])
        );
    end

endmodule

// File: tb/tb_noc_clk_gate_ctrl.sv
// Directed and randomized bench for noc_clk_gate_ctrl with a cycle-level behavioural model.
module tb_noc_clk_gate_ctrl;

    localparam int NCH = 4;
    localparam int IW  = 8;
    localparam int WC  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           test_en;
    logic [IW-1:0]  thr;
    logic [NCH-1:0] idle, force_on, req;
    logic [NCH-1:0] ack, oclk, gated;

    always #5 clk = ~clk;

    noc_clk_gate_ctrl #(.NUM_CH(NCH), .IDLE_CNT_W(IW), .WAKE_CYCLES(WC)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_test_en        (test_en),
        .i_idle_threshold (thr),
        .i_idle           (idle),
        .i_force_on       (force_on),
        .i_wake_req       (req),
        .o_wake_ack       (ack),
        .o_clk            (oclk),
        .o_gated          (gated)
    );

    int edges0 = 0;
    always @(posedge oclk[0]) edges0++;

    // Model: gated flag, length of current idle run, remaining wake cycles, last ack.
    bit m_gated[NCH];
    int m_run[NCH];
    int m_wake[NCH];
    bit m_ack[NCH];

    int total = 0;
    int bad   = 0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < NCH; i++) begin
            bit cond;
            bit nack;
            cond = idle[i] && !force_on[i] && !req[i] && (thr != 0);
            nack = 1'b0;
            if (rst) begin
                m_gated[i] = 1'b0;
                m_run[i]   = 0;
                m_wake[i]  = 0;
            end else if (m_wake[i] > 0) begin
                m_wake[i] = m_wake[i] - 1;
                if (m_wake[i] == 0) nack = req[i];
            end else if (m_gated[i]) begin
                if (req[i] || force_on[i] || !idle[i] || thr == 0) begin
                    m_gated[i] = 1'b0;
                    m_wake[i]  = WC;
                end
            end else if (m_run[i] == 0) begin
                nack = req[i] && !m_ack[i];
                if (cond) m_run[i] = 1;
            end else if (!cond) begin
                m_run[i] = 0;
            end else if (m_run[i] >= int'(thr)) begin
                m_gated[i] = 1'b1;
                m_run[i]   = 0;
            end else if (m_run[i] < 255) begin
                m_run[i] = m_run[i] + 1;
            end
            m_ack[i] = nack;
        end
    endtask

    // Advance one clock; the clock of a channel runs at this edge if its enable was high before it.
    task automatic step(input bit do_chk);
        bit exp_run[NCH];
        for (int i = 0; i < NCH; i++) exp_run[i] = !m_gated[i] || test_en;
        model_update();
        @(posedge clk);
        #1;
        if (do_chk) begin
            for (int i = 0; i < NCH; i++) begin
                check_bit($sformatf("gated%0d", i), gated[i], m_gated[i]);
                check_bit($sformatf("ack%0d", i), ack[i], m_ack[i]);
                check_bit($sformatf("clkrun%0d", i), oclk[i], exp_run[i]);
            end
        end
    endtask

    initial begin
        int n;
        int e0;
        int acks;
        bit any;

        rst = 1'b1; test_en = 1'b0; thr = 8'd4;
        idle = 4'b0000; force_on = 4'b0000; req = 4'b0000;
        for (int i = 0; i < NCH; i++) begin
            m_gated[i] = 1'b0; m_run[i] = 0; m_wake[i] = 0; m_ack[i] = 1'b0;
        end
        step(1'b0);
        step(1'b0);
        step(1'b1);
        rst = 1'b0;
        step(1'b1);
        check_int("reset_gated", int'(gated), 0);
        check_int("reset_ack", int'(ack), 0);

        // Idle to gated latency with threshold 4
        idle[0] = 1'b1;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1);
            n = k;
            if (gated[0]) break;
        end
        check_int("gate_latency", n, 5);
        step(1'b1);
        check_bit("clk_stopped", oclk[0], 1'b0);

        // Wake handshake
        req[0] = 1'b1;
        e0 = edges0;
        step(1'b1);
        check_bit("wake_ungated", gated[0], 1'b0);
        n = 1;
        for (int k = 2; k <= 8; k++) begin
            step(1'b1);
            n = k;
            if (ack[0]) break;
        end
        check_int("wake_latency", n, 1 + WC);
        check_bit("wake_edges", (edges0 - e0) >= 2, 1'b1);
        req[0] = 1'b0;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            acks += int'(ack[0]);
        end
        check_int("wake_single_ack", acks, 0);

        // Idle drop at counter 3 restarts the run
        idle[0] = 1'b0;
        for (int k = 0; k < 6; k++) step(1'b1);
        idle[0] = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1);
        idle[0] = 1'b0;
        step(1'b1);
        check_bit("drop_ungated", gated[0], 1'b0);
        idle[0] = 1'b1;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1);
            n = k;
            if (gated[0]) break;
        end
        check_int("regate_latency", n, 5);

        // Threshold 0 disables gating; 8 gates; back to 0 wakes without ack
        idle[0] = 1'b0;
        for (int k = 0; k < 6; k++) step(1'b1);
        thr = 8'd0;
        idle = 4'b1111;
        any = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1);
            any = any | (|gated);
        end
        check_bit("thr0_no_gate", any, 1'b0);
        thr = 8'd8;
        n = 0;
        for (int k = 1; k <= 16; k++) begin
            step(1'b1);
            n = k;
            if (gated[0]) break;
        end
        check_int("thr8_latency", n, 9);
        thr = 8'd0;
        step(1'b1);
        check_bit("thr0_wakes", gated[0], 1'b0);
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            acks += int'(ack[0]);
        end
        check_int("thr0_no_ack", acks, 0);

        // Test enable with all channels gated
        thr = 8'd2;
        for (int k = 0; k < 8; k++) step(1'b1);
        check_int("all_gated", int'(gated), 15);
        test_en = 1'b1;
        for (int k = 0; k < 6; k++) step(1'b1);
        check_int("te_clk_on", int'(oclk), 15);
        check_int("te_gated_hold", int'(gated), 15);
        test_en = 1'b0;
        step(1'b1);
        check_int("te_fsm_hold", int'(gated), 15);

        // Staggered wake and reset in the middle of WAKE
        req[1] = 1'b1;
        step(1'b1);
        req[2] = 1'b1;
        step(1'b1);
        idle[3] = 1'b0;
        step(1'b1);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        req = 4'b0000;
        check_int("rst_gated", int'(gated), 0);
        check_int("rst_ack", int'(ack), 0);

        // Randomized traffic against the model
        thr = 8'd3;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 7) == 0) idle[i] = ~idle[i];
                if ($urandom_range(0, 39) == 0) force_on[i] = ~force_on[i];
                if (m_ack[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 19) == 0) req[i] = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) thr = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 63) == 0) test_en = ~test_en;
            rst = ($urandom_range(0, 199) == 0);
            step(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
